// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and ID-branch operand stalls, IF/ID flush on
// taken redirect, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int          CNT_W      = 32,
  parameter logic [2:0]  NPC_BRANCH = 3'b001,
  parameter logic [2:0]  NPC_JUMP   = 3'b010,
  parameter logic [2:0]  NPC_JALR   = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [2:0]       NPCOp,
  input  logic             branch_taken,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_MemRead,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic       branch_class;
  logic       match_ex;
  logic       match_mem;
  logic [1:0] need;
  logic       stall;
  logic       flush;

  assign branch_class = (NPCOp == NPC_BRANCH) || (NPCOp == NPC_JALR) || (NPCOp == NPC_JUMP);

  // A reader of x0 or an unused operand can never depend on an in-flight result.
  assign match_ex  = (use_rs1 && IF_ID_rs1 != 5'd0 && IF_ID_rs1 == ID_EX_rd) ||
                     (use_rs2 && IF_ID_rs2 != 5'd0 && IF_ID_rs2 == ID_EX_rd);
  assign match_mem = (use_rs1 && IF_ID_rs1 != 5'd0 && IF_ID_rs1 == EX_MEM_rd) ||
                     (use_rs2 && IF_ID_rs2 != 5'd0 && IF_ID_rs2 == EX_MEM_rd);

  always_comb begin
    need = 2'd0;
    if (branch_class && ID_EX_MemRead && match_ex)
      need = 2'd2;
    else if (branch_class && ID_EX_RegWrite && match_ex)
      need = 2'd1;
    else if (branch_class && EX_MEM_MemRead && match_mem)
      need = 2'd1;
    else if (!branch_class && ID_EX_MemRead && match_ex)
      need = 2'd1;
  end

  always_comb begin
    stall      = 1'b0;
    state_next = IDLE;
    if (!rst) begin
      if (state_reg == STALL) begin
        stall = 1'b1;
      end else begin
        stall = (need != 2'd0);
        if (need == 2'd2)
          state_next = STALL;
      end
    end
  end

  // Stale operands make branch_taken meaningless while stalled.
  assign flush        = !rst && !stall && branch_taken;
  assign PC_write     = !stall;
  assign IF_ID_write  = !stall;
  assign ID_EX_bubble = stall;
  assign IF_ID_flush  = flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      state_reg <= state_next;
      if (stall && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush && flush_cycles != CNT_MAX)
        flush_cycles <= flush_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences plus random traffic,
// checked against a behavioural model on a 32-bit and a 2-bit counter instance.
module tb_hazard_ctrl;

  localparam logic [2:0] BR   = 3'b001;
  localparam logic [2:0] JMP  = 3'b010;
  localparam logic [2:0] JALR = 3'b100;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [2:0] npc;
    logic       bt;
    logic [4:0] ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
  } stim_t;

  typedef struct {
    logic        pcw, ifw, bub, flush;
    logic [31:0] sc, fc;
    logic [1:0]  sc_s, fc_s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, ex_rd = '0, mem_rd = '0;
  logic        use1 = 0, use2 = 0, bt = 0, ex_rw = 0, ex_mr = 0, mem_mr = 0;
  logic [2:0]  npc = '0;
  logic        pcw, ifw, bub, flush, pcw_s, ifw_s, bub_s, flush_s;
  logic [31:0] sc, fc;
  logic [1:0]  sc_s, fc_s;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .use_rs1(use1), .use_rs2(use2),
    .NPCOp(npc), .branch_taken(bt), .ID_EX_rd(ex_rd), .ID_EX_RegWrite(ex_rw),
    .ID_EX_MemRead(ex_mr), .EX_MEM_rd(mem_rd), .EX_MEM_MemRead(mem_mr),
    .PC_write(pcw), .IF_ID_write(ifw), .ID_EX_bubble(bub), .IF_ID_flush(flush),
    .stall_cycles(sc), .flush_cycles(fc)
  );

  hazard_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .use_rs1(use1), .use_rs2(use2),
    .NPCOp(npc), .branch_taken(bt), .ID_EX_rd(ex_rd), .ID_EX_RegWrite(ex_rw),
    .ID_EX_MemRead(ex_mr), .EX_MEM_rd(mem_rd), .EX_MEM_MemRead(mem_mr),
    .PC_write(pcw_s), .IF_ID_write(ifw_s), .ID_EX_bubble(bub_s), .IF_ID_flush(flush_s),
    .stall_cycles(sc_s), .flush_cycles(fc_s)
  );

  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;
  exp_t sb_q[$];

  // Reference model state: stall cycles still owed, and plain integer counters.
  int          owed = 0;
  longint      m_sc = 0, m_fc = 0, m_sc_s = 0, m_fc_s = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 0, rs1: 0, rs2: 0, use1: 0, use2: 0, npc: 0, bt: 0,
          ex_rd: 0, ex_rw: 0, ex_mr: 0, mem_rd: 0, mem_mr: 0};
    return s;
  endfunction

  function automatic bit reads(stim_t s, logic [4:0] r);
    return r != 0 && ((s.use1 && s.rs1 == r) || (s.use2 && s.rs2 == r));
  endfunction

  function automatic int stalls_needed(stim_t s);
    bit ctl = (s.npc == BR) || (s.npc == JMP) || (s.npc == JALR);
    if (ctl && s.ex_mr && reads(s, s.ex_rd)) return 2;
    if (ctl && s.ex_rw && reads(s, s.ex_rd)) return 1;
    if (ctl && s.mem_mr && reads(s, s.mem_rd)) return 1;
    if (!ctl && s.ex_mr && reads(s, s.ex_rd)) return 1;
    return 0;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    rst = s.rst; rs1 = s.rs1; rs2 = s.rs2; use1 = s.use1; use2 = s.use2; npc = s.npc;
    bt = s.bt; ex_rd = s.ex_rd; ex_rw = s.ex_rw; ex_mr = s.ex_mr; mem_rd = s.mem_rd;
    mem_mr = s.mem_mr;
    if (s.rst) begin
      st = 0;
      e.flush = 0;
    end else if (owed > 0) begin
      st = 1;
      e.flush = 0;
      owed--;
    end else begin
      int n = stalls_needed(s);
      st = (n > 0);
      owed = (n > 0) ? n - 1 : 0;
      e.flush = !st && s.bt;
    end
    e.pcw = !st; e.ifw = !st; e.bub = st;
    e.sc = 32'(m_sc); e.fc = 32'(m_fc); e.sc_s = 2'(m_sc_s); e.fc_s = 2'(m_fc_s);
    sb_q.push_back(e);
    if (s.rst) begin
      owed = 0; m_sc = 0; m_fc = 0; m_sc_s = 0; m_fc_s = 0;
    end else begin
      if (st) begin m_sc++; if (m_sc_s < 3) m_sc_s++; end
      if (e.flush) begin m_fc++; if (m_fc_s < 3) m_fc_s++; end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL txn%0d %s: got %0d expected %0d", txn, name, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("PC_write", pcw, e.pcw);
        chk("IF_ID_write", ifw, e.ifw);
        chk("ID_EX_bubble", bub, e.bub);
        chk("IF_ID_flush", flush, e.flush);
        chk("stall_cycles", sc, e.sc);
        chk("flush_cycles", fc, e.fc);
        chk("small_bubble", bub_s, e.bub);
        chk("small_flush", flush_s, e.flush);
        chk("small_stall_cycles", sc_s, e.sc_s);
        chk("small_flush_cycles", fc_s, e.fc_s);
        $display("[TB] txn %0d rst=%0b bub=%0b flush=%0b sc=%0d fc=%0d sc2=%0d",
                 txn, rst, bub, flush, sc, fc, sc_s);
        txn++;
      end
    end
  end

  initial begin
    stim_t s, lu, lb;
    lu = idle(); lu.ex_mr = 1; lu.ex_rd = 5; lu.rs2 = 5; lu.use2 = 1;
    lb = idle(); lb.ex_mr = 1; lb.ex_rd = 7; lb.rs1 = 7; lb.use1 = 1; lb.npc = BR; lb.bt = 1;

    // Reset held with a hazard present, then a quiet cycle.
    s = lu; s.rst = 1; apply(s); apply(s);
    apply(idle());
    // Load-use, then hazard removed.
    apply(lu); apply(idle());
    // Load -> taken beq: two stalls (second with changed inputs), then flush.
    apply(lb);
    s = idle(); s.ex_rw = 1; s.ex_rd = 3; s.rs1 = 3; s.use1 = 1; s.npc = JMP; apply(s);
    s = idle(); s.npc = BR; s.bt = 1; apply(s);
    // x0 producer and unused operand never stall.
    s = idle(); s.ex_mr = 1; s.use1 = 1; apply(s);
    s = lu; s.use2 = 0; apply(s);
    // ALU -> jalr and load-in-MEM -> branch each give one stall.
    s = idle(); s.ex_rw = 1; s.ex_rd = 9; s.rs2 = 9; s.use2 = 1; s.npc = JALR; s.bt = 1; apply(s);
    s = idle(); s.mem_mr = 1; s.mem_rd = 4; s.rs1 = 4; s.use1 = 1; s.npc = BR; apply(s);
    // Reset in the STALL cycle abandons it.
    apply(lb);
    s = lb; s.rst = 1; apply(s);
    apply(idle());
    // Five consecutive load-use stalls saturate the 2-bit counter.
    repeat (5) apply(lu);
    apply(idle());

    // Random traffic over a small register range to make hazards frequent.
    for (int i = 0; i < 300; i++) begin
      s.rst    = ($urandom_range(0, 39) == 0);
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.use1   = 1'($urandom);
      s.use2   = 1'($urandom);
      case ($urandom_range(0, 4))
        0: s.npc = BR;
        1: s.npc = JMP;
        2: s.npc = JALR;
        3: s.npc = 3'b000;
        default: s.npc = 3'b011;
      endcase
      s.bt     = 1'($urandom);
      s.ex_rd  = 5'($urandom_range(0, 3));
      s.ex_rw  = 1'($urandom);
      s.ex_mr  = 1'($urandom);
      s.mem_rd = 5'($urandom_range(0, 3));
      s.mem_mr = 1'($urandom);
      apply(s);
    end

    begin
      int budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(posedge clk);
      tests++;
      if (sb_q.size() != 0) begin
        fails++;
        $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage PCPU. It sits upstream of the forwarding unit and the ID/EX register, and handles the cases that forwarding alone cannot resolve: load-use hazards, and branch/jump operands needed in ID before they exist. It freezes PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on a taken control transfer. A two-state FSM handles the two-cycle load-then-branch case, and saturating counters record stall and flush cycles for performance analysis.

## Interface
- CNT_W, 32, width of the stall/flush performance counters
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID
- use_rs1, use_rs2  in  1 each  ID instruction actually reads rs1 / rs2
- NPCOp  in  3  NPC op of the ID instruction; "branch-class" = `NPC_BRANCH`, `NPC_JALR` or `NPC_JUMP` (ctrl_encode_def.v)
- branch_taken  in  1  ID-resolved redirect (taken branch, jal, jalr)
- ID_EX_rd  in  5  destination of the instruction in EX
- ID_EX_RegWrite, ID_EX_MemRead  in  1 each  control bits of the instruction in EX
- EX_MEM_rd  in  5  destination of the instruction in MEM
- EX_MEM_MemRead  in  1  instruction in MEM is a load
- PC_write  out  1  1 = PC may update
- IF_ID_write  out  1  1 = IF/ID may load
- ID_EX_bubble  out  1  1 = load a NOP (all control zero) into ID/EX
- IF_ID_flush  out  1  1 = clear IF/ID to NOP
- stall_cycles  out  CNT_W  count of cycles with stall asserted
- flush_cycles  out  CNT_W  count of cycles with IF_ID_flush asserted

## Operation
- match1 = use_rs1 && rs1!=0 && rs1==X. match2 is the same for rs2. matchX = match1 || match2.
- Stall need n is evaluated in IDLE only. The first rule that applies sets n:
  - branch-class && ID_EX_MemRead && match(ID_EX_rd) -> n=2
  - branch-class && ID_EX_RegWrite && match(ID_EX_rd) -> n=1
  - branch-class && EX_MEM_MemRead && match(EX_MEM_rd) -> n=1
  - !branch-class && ID_EX_MemRead && match(ID_EX_rd) -> n=1
  - otherwise n=0
- FSM states: IDLE, STALL.
  - IDLE, n=0: no stall. IF_ID_flush = branch_taken. Next state IDLE.
  - IDLE, n=1: stall = 1. Next state IDLE, so the following cycle re-evaluates.
  - IDLE, n=2: stall = 1. Next state STALL.
  - STALL: stall = 1 unconditionally, and all inputs are ignored. Next state IDLE.
- When stall is 1: PC_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, IF_ID_flush = 0. A stall suppresses branch_taken because the operands are stale.
- When stall is 0: PC_write = 1, IF_ID_write = 1, ID_EX_bubble = 0.
- Outputs are Mealy: combinational from the current state and the current inputs.
- Counters:
  - stall_cycles increments on each cycle with stall = 1.
  - flush_cycles increments on each cycle with IF_ID_flush = 1.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- While rst is high:
  - State returns to IDLE and both counters clear to 0 on the next edge.
  - Outputs are forced to PC_write=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush=0, independent of inputs.
- Reset asserted in STALL abandons the stall. The first cycle after reset evaluates from IDLE.
- Detection latency is zero: the stall is visible in the same cycle the hazard inputs are presented.
- The load→branch sequence gives exactly 2 stall cycles (t, t+1). At t+2 the load is in WB, so the forwarding unit's MEM/WB→ID path supplies the operand.
- ALU→branch gives 1 stall. At t+1 the producer is in MEM and is forwarded to ID.
- Simultaneous events:
  - A hazard and branch_taken in the same cycle -> stall wins, no flush.
  - branch_taken is honoured on the first non-stall cycle.
- rd = x0 never causes a stall.

## Test plan
- Reset: hold rst for 2 cycles with a hazard present on the inputs. -> PC_write=1, ID_EX_bubble=0. After reset, both counters = 0.
- Load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5, use_rs2=1, NPCOp non-branch. -> 1 stall cycle; stall_cycles=1; next cycle with the hazard removed has no stall.
- Load→beq: ID_EX_MemRead=1, ID_EX_rd=7, rs1=7, NPCOp=`NPC_BRANCH`, branch_taken=1. -> stall at t and t+1 (the t+1 stall holds even if inputs change). At t+2 with no hazard: IF_ID_flush=1, stall_cycles=2, flush_cycles=1.
- x0 / unused operand:
  - ID_EX_rd=0 with ID_EX_MemRead=1 and rs1=0 -> no stall.
  - rs2 match with use_rs2=0 -> no stall.
- Reset mid-STALL: trigger the n=2 case, then assert rst in the STALL cycle. -> outputs immediately report no stall; state IDLE; counters 0.
- Saturation: CNT_W=2 with 5 consecutive stall cycles. -> stall_cycles holds at 3.
